fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction word presented to decode on bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit hold; freezes PC and IF/ID outputs.
REQ-006 redirect  input  1  branch/jump taken; load redirect_pc and flush IF/ID.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  instruction-memory read address, word aligned.
REQ-010 imem_ready  input  1  memory has valid read data this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-012 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-013 if_id_instr  output  32  instruction to decode / immediate generator.
REQ-014 if_id_pc  output  32  address of if_id_instr.
REQ-015 if_id_pc4  output  32  if_id_pc + 4 (link value for JAL/JALR).
REQ-016 misalign  output  1  one-cycle pulse on non-word-aligned redirect target.

Function
REQ-017 FSM states IDLE, FETCH, WAIT, KILL; reset state IDLE.
REQ-018 IDLE -> FETCH unconditionally on first clock after reset deasserts; imem_req=0 in IDLE.
REQ-019 imem_req=1 in FETCH, WAIT, KILL; imem_addr shall equal internal pc in FETCH, and be held unchanged in WAIT and KILL until imem_ready.
REQ-020 FETCH, imem_ready=1, stall=0, redirect=0: capture if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4; stay FETCH (1 instruction/cycle, latency 1 cycle addr->IF/ID).
REQ-021 FETCH, imem_ready=0, no redirect: go WAIT; if stall=0, if_id_valid<=0 and if_id_instr<=NOP_INSTR.
REQ-022 WAIT, imem_ready=1, no redirect: behave as REQ-020 (capture if stall=0), return FETCH.
REQ-023 stall=1, redirect=0: pc and all if_id_* hold; a returning response is discarded and the same address refetched.
REQ-024 redirect has priority over stall; IF/ID flush: if_id_valid<=0, if_id_instr<=NOP_INSTR, pc<=aligned redirect_pc.
REQ-025 redirect in FETCH (ready or not ready): any same-cycle data discarded; next state FETCH at new pc, address changes next cycle.
REQ-026 redirect in WAIT with imem_ready=0: go KILL; pc<=target while imem_addr holds old address.
REQ-027 KILL: hold old address until imem_ready=1, discard that data, then FETCH at pc; further redirect in KILL only updates pc.
REQ-028 redirect in WAIT with imem_ready=1: data discarded, go FETCH at target.
REQ-029 pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-030 imem_addr[1:0] shall always be 2'b00.

Reset
REQ-031 Asynchronous assert: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, misalign=0.
REQ-032 Reset mid-transaction (WAIT/KILL) abandons the request; no data from it reaches IF/ID.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 pulses misalign=1 for the cycle after redirect, and pc<={redirect_pc[31:2],2'b00}.
REQ-034 Macro undefined: misalign tied 0; low two bits of redirect_pc silently cleared.

Verification
REQ-035 Reset release, imem_ready=1 always, memory returns addr^32'hA5A5_0000 -> first if_id_valid 2 cycles after release, if_id_pc=0,4,8 consecutive, if_id_pc4=pc+4.
REQ-036 imem_ready low 3 cycles at addr 0x10 -> imem_addr stable 0x10, if_id_valid=0 with NOP 32'h0000_0013, then instr from 0x10 captured.
REQ-037 stall=1 for 2 cycles with if_id_pc=0x20 -> if_id_* unchanged, after release next if_id_pc=0x24.
REQ-038 redirect to 0x100 during WAIT on 0x40 (stall=1 same cycle) -> KILL, stale 0x40 data never valid, next valid if_id_pc=0x100.
REQ-039 RESET_PC=32'hFFFF_FFFC -> if_id_pc sequence FFFF_FFFC, 0000_0000.
REQ-040 With FETCH_MISALIGN_CHK_EN, redirect_pc=0x102 -> misalign pulse 1 cycle, next valid if_id_pc=0x100; without macro misalign stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues instruction-memory reads and fills the IF/ID register.
// Define FETCH_MISALIGN_CHK_EN to flag redirect targets that are not word aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, KILL} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] hold_addr;
    logic [31:0] addr_sel;
    logic [31:0] target;
    logic        capture;
    logic        bubble;

    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WAIT and KILL keep presenting the address of the outstanding request,
    // while pc may already point at a redirect target.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        bubble     = 1'b0;
        imem_req   = 1'b1;
        addr_sel   = pc;
        case (state)
            IDLE: begin
                imem_req   = 1'b0;
                state_next = FETCH;
                if (redirect) begin
                    bubble  = 1'b1;
                    pc_next = target;
                end
            end
            FETCH: begin
                if (redirect) begin
                    bubble  = 1'b1;
                    pc_next = target;
                end else if (imem_ready) begin
                    if (!stall) begin
                        capture = 1'b1;
                        pc_next = pc_plus4;
                    end
                end else begin
                    state_next = WAIT;
                    bubble     = !stall;
                end
            end
            WAIT: begin
                addr_sel = hold_addr;
                if (redirect) begin
                    bubble     = 1'b1;
                    pc_next    = target;
                    state_next = imem_ready ? FETCH : KILL;
                end else if (imem_ready) begin
                    state_next = FETCH;
                    if (!stall) begin
                        capture = 1'b1;
                        pc_next = pc_plus4;
                    end
                end else begin
                    bubble = !stall;
                end
            end
            KILL: begin
                addr_sel = hold_addr;
                if (redirect) begin
                    bubble  = 1'b1;
                    pc_next = target;
                end else begin
                    bubble = !stall;
                end
                if (imem_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr = addr_sel & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            hold_addr   <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0000_0000;
            if_id_pc4   <= 32'h0000_0000;
        end else begin
            pc <= pc_next;
            if (state == IDLE || state == FETCH) begin
                hold_addr <= pc;
            end
            if (capture) begin
                if_id_valid <= 1'b1;
                if_id_instr <= imem_rdata;
                if_id_pc    <= pc;
                if_id_pc4   <= pc_plus4;
            end else if (bubble) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        misalign;

    logic        reset2;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_mis;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign w_rdata    = w_addr ^ 32'hA5A5_0000;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0000_0000), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rdata(w_rdata), .if_id_valid(w_valid),
        .if_id_instr(w_instr), .if_id_pc(w_pc), .if_id_pc4(w_pc4),
        .misalign(w_mis)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %0b want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_addr: got %h want 00000000", imem_addr); end
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %0b want 0", if_id_valid); end
        vectors++; if (if_id_instr !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL rst_instr: got %h want 00000013", if_id_instr); end
        vectors++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pc: got %h/%h want 0/0", if_id_pc, if_id_pc4); end
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_misalign: got %0b want 0", misalign); end
        vectors++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wrap_addr: got %h req %0b want fffffffc req 0", w_addr, w_req); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        reset = 1'b0;
        tick;
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_first_valid: got %0b want 0", if_id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL stream_first_req: got %0b/%h want 1/00000000", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick;
            exp_pc = 32'(i * 4);
            vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc) begin miscompares++; $display("[TB] FAIL stream_pc%0d: got v%0b %h want v1 %h", i, if_id_valid, if_id_pc, exp_pc); end
            vectors++; if (if_id_pc4 !== exp_pc + 32'd4) begin miscompares++; $display("[TB] FAIL stream_pc4_%0d: got %h want %h", i, if_id_pc4, exp_pc + 32'd4); end
            vectors++; if (if_id_instr !== (exp_pc ^ 32'hA5A5_0000)) begin miscompares++; $display("[TB] FAIL stream_instr%0d: got %h want %h", i, if_id_instr, exp_pc ^ 32'hA5A5_0000); end
        end
    endtask

    task automatic test_wait;
        tick;
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL wait_addr_pre: got %h want 00000010", imem_addr); end
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_addr%0d: got %h req %0b want 00000010 req 1", i, imem_addr, imem_req); end
            vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0000_0013) begin miscompares++; $display("[TB] FAIL wait_bubble%0d: got v%0b %h want v0 00000013", i, if_id_valid, if_id_instr); end
        end
        imem_ready = 1'b1;
        tick;
        vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 || if_id_instr !== 32'hA5A5_0010) begin miscompares++; $display("[TB] FAIL wait_capture: got v%0b %h %h want v1 00000010 a5a50010", if_id_valid, if_id_pc, if_id_instr); end
        vectors++; if (imem_addr !== 32'h14) begin miscompares++; $display("[TB] FAIL wait_next_addr: got %h want 00000014", imem_addr); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) tick;
        vectors++; if (if_id_pc !== 32'h20) begin miscompares++; $display("[TB] FAIL stall_pre_pc: got %h want 00000020", if_id_pc); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20 || if_id_pc4 !== 32'h24 || if_id_instr !== 32'hA5A5_0020) begin miscompares++; $display("[TB] FAIL stall_hold%0d: got v%0b %h %h %h want v1 00000020 00000024 a5a50020", i, if_id_valid, if_id_pc, if_id_pc4, if_id_instr); end
            vectors++; if (imem_addr !== 32'h24) begin miscompares++; $display("[TB] FAIL stall_addr%0d: got %h want 00000024", i, imem_addr); end
        end
        stall = 1'b0;
        tick;
        vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h24 || if_id_instr !== 32'hA5A5_0024) begin miscompares++; $display("[TB] FAIL stall_release: got v%0b %h %h want v1 00000024 a5a50024", if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_kill;
        for (int i = 0; i < 6; i++) tick;
        vectors++; if (imem_addr !== 32'h40 || if_id_pc !== 32'h3C) begin miscompares++; $display("[TB] FAIL kill_pre: got addr %h pc %h want 00000040 0000003c", imem_addr, if_id_pc); end
        imem_ready = 1'b0;
        tick;
        vectors++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_wait: got %h v%0b want 00000040 v0", imem_addr, if_id_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        stall       = 1'b1;
        tick;
        redirect = 1'b0;
        stall    = 1'b0;
        vectors++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_enter: got %h req %0b v%0b want 00000040 req 1 v0", imem_addr, imem_req, if_id_valid); end
        tick;
        vectors++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_hold: got %h v%0b want 00000040 v0", imem_addr, if_id_valid); end
        imem_ready = 1'b1;
        tick;
        vectors++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL kill_discard: got v%0b addr %h want v0 00000100", if_id_valid, imem_addr); end
        tick;
        vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_pc4 !== 32'h104 || if_id_instr !== 32'hA5A5_0100) begin miscompares++; $display("[TB] FAIL kill_target: got v%0b %h %h %h want v1 00000100 00000104 a5a50100", if_id_valid, if_id_pc, if_id_pc4, if_id_instr); end
    endtask

    task automatic test_misalign;
        logic exp_mis;
`ifdef FETCH_MISALIGN_CHK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick;
        redirect = 1'b0;
        vectors++; if (misalign !== exp_mis) begin miscompares++; $display("[TB] FAIL mis_pulse: got %0b want %0b", misalign, exp_mis); end
        vectors++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_flush: got %h v%0b want 00000100 v0", imem_addr, if_id_valid); end
        tick;
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_clear: got %0b want 0", misalign); end
        vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL mis_target: got v%0b %h want v1 00000100", if_id_valid, if_id_pc); end
    endtask

    task automatic test_reset_mid;
        imem_ready = 1'b0;
        tick;
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin miscompares++; $display("[TB] FAIL rstmid_async: got req %0b %h v%0b %h want 0 00000000 v0 00000013", imem_req, imem_addr, if_id_valid, if_id_instr); end
        imem_ready = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        vectors++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rstmid_idle: got v%0b %h want v0 00000000", if_id_valid, imem_addr); end
        tick;
        vectors++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'hA5A5_0000) begin miscompares++; $display("[TB] FAIL rstmid_first: got v%0b %h %h want v1 00000000 a5a50000", if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_wrap;
        reset2 = 1'b0;
        tick;
        vectors++; if (w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_addr: got %h v%0b want fffffffc v0", w_addr, w_valid); end
        tick;
        vectors++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_first: got v%0b %h %h want v1 fffffffc 00000000", w_valid, w_pc, w_pc4); end
        tick;
        vectors++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_pc4 !== 32'h4 || w_instr !== 32'hA5A5_0000) begin miscompares++; $display("[TB] FAIL wrap_second: got v%0b %h %h %h want v1 00000000 00000004 a5a50000", w_valid, w_pc, w_pc4, w_instr); end
    endtask

    initial begin
        reset       = 1'b1;
        reset2      = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        tick;
        tick;
        test_reset;
        test_stream;
        test_wait;
        test_stall;
        test_kill;
        test_misalign;
        test_reset_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
